// File: rtl/dynamic_tmr.sv
// Dynamically switched simplex/TMR command processor with err_rate hysteresis.
// Optional replica fault injection via an 8-bit LFSR when DTMR_FAULT_INJ_EN is defined.
module dynamic_tmr #(
  parameter int TMR_ON_TH  = 8,
  parameter int TMR_OFF_TH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] speed,
  input  logic [3:0] dir,
  input  logic [1:0] mode,
  input  logic [3:0] err_rate,
  input  logic       f1,
  input  logic       f2,
  input  logic       b1,
  input  logic       b2,
  output logic [3:0] speed_o,
  output logic [3:0] dir_o,
  output logic [2:0] fault,
  output logic       state_o
);

  localparam logic [3:0] ON_TH  = 4'(TMR_ON_TH);
  localparam logic [3:0] OFF_TH = 4'(TMR_OFF_TH);

  typedef enum logic {SIMPLEX = 1'b0, TMR = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [7:0] res_p0 [3];
  logic [7:0] voted_p0;
  logic [7:0] out_p0;
  logic [2:0] fault_p0;
  logic [2:0] inj_sel;

  function automatic logic [7:0] replica(input logic [3:0] spd, input logic [3:0] dr,
                                         input logic [1:0] md, input logic fa, input logic fb,
                                         input logic ba, input logic bb);
    logic path_blk;
    logic [7:0] r;
    path_blk = dr[3] ? (~ba | ~bb) : (~fa | ~fb);
    case (md)
      2'd0:    r = {(path_blk ? 4'd0 : spd), dr};
      2'd1:    r = {(path_blk ? (spd >> 1) : spd), dr};
      2'd2:    r = {spd, dr};
      default: r = 8'd0;
    endcase
    return r;
  endfunction

`ifdef DTMR_FAULT_INJ_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) lfsr <= 8'hA5;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  // LFSR[5:4] == 3 wraps onto replica 0 (mod 3)
  always_comb begin
    inj_sel = 3'b000;
    if (lfsr[3:0] < err_rate) begin
      case (lfsr[5:4])
        2'd1:    inj_sel = 3'b010;
        2'd2:    inj_sel = 3'b100;
        default: inj_sel = 3'b001;
      endcase
    end
  end
`else
  assign inj_sel = 3'b000;
`endif

  // Stage p0: replicas, vote and selection on the pre-update state
  for (genvar i = 0; i < 3; i++) begin : g_rep
    assign res_p0[i] = replica(speed, dir, mode, f1, f2, b1, b2) ^ {7'd0, inj_sel[i]};
  end

  assign voted_p0 = (res_p0[0] & res_p0[1]) | (res_p0[0] & res_p0[2]) | (res_p0[1] & res_p0[2]);

  always_comb begin
    out_p0   = res_p0[0];
    fault_p0 = 3'b000;
    if (state == TMR) begin
      out_p0 = voted_p0;
      for (int i = 0; i < 3; i++) fault_p0[i] = (res_p0[i] != voted_p0);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SIMPLEX: if (err_rate >= ON_TH)  state_nxt = TMR;
      TMR:     if (err_rate <  OFF_TH) state_nxt = SIMPLEX;
      default: state_nxt = SIMPLEX;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= SIMPLEX;
    else     state <= state_nxt;
  end

  // Stage p1: registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      speed_o <= 4'd0;
      dir_o   <= 4'd0;
      fault   <= 3'b000;
    end else begin
      speed_o <= out_p0[7:4];
      dir_o   <= out_p0[3:0];
      fault   <= fault_p0;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_dynamic_tmr.sv
// Scoreboard bench for dynamic_tmr: driver queues hand-computed expectations,
// monitor pops one per clock and compares the registered outputs.
module tb_dynamic_tmr;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] speed, dir, err_rate;
  logic [1:0] mode;
  logic       f1, f2, b1, b2;
  logic [3:0] speed_o, dir_o;
  logic [2:0] fault;
  logic       state_o;

  typedef struct {
    logic [3:0] sp;
    logic [3:0] dr;
    logic       st;
    bit         chk_out;
    bit         chk_ft;
    bit         inj;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   inj_on;
  bit   seen_onehot = 0;
  logic prev_st = 1'b0;

  dynamic_tmr dut (
    .clk(clk), .rst(rst), .speed(speed), .dir(dir), .mode(mode), .err_rate(err_rate),
    .f1(f1), .f2(f2), .b1(b1), .b2(b2),
    .speed_o(speed_o), .dir_o(dir_o), .fault(fault), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // sens = {f1,f2,b1,b2}; expected outputs are for the edge that samples these inputs
  task automatic drive(input logic r, input logic [3:0] s, input logic [3:0] d,
                       input logic [1:0] m, input logic [3:0] e, input logic [3:0] sens,
                       input logic [3:0] es, input logic [3:0] ed, input logic est,
                       input bit inj_vec);
    exp_t x;
    @(negedge clk);
    rst = r; speed = s; dir = d; mode = m; err_rate = e;
    {f1, f2, b1, b2} = sens;
    x.sp = es; x.dr = ed; x.st = est; x.inj = inj_vec;
    x.chk_ft  = !inj_on || r || e == 4'd0;
    x.chk_out = !inj_on || r || e == 4'd0 || prev_st == 1'b1;
    q.push_back(x);
    prev_st = est;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("state_o", {3'd0, state_o}, {3'd0, x.st});
        if (x.chk_out) begin
          chk("speed_o", speed_o, x.sp);
          chk("dir_o", dir_o, x.dr);
        end
        if (x.chk_ft) chk("fault", {1'b0, fault}, 4'd0);
        if (x.inj) begin
          chk("fault_onehot0", {3'd0, $onehot0(fault)}, 4'd1);
          if ($onehot(fault)) seen_onehot = 1;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
`ifdef DTMR_FAULT_INJ_EN
    inj_on = 1;
`else
    inj_on = 0;
`endif
    rst = 1; speed = 0; dir = 0; mode = 0; err_rate = 0;
    {f1, f2, b1, b2} = 4'b1111;
    //     rst spd dir mode err sens     es  ed  st
    drive(1, 10,  5, 0,  0, 4'b1111,  0,  0, 0, 0);
    drive(0, 10,  5, 0,  0, 4'b0011,  0,  5, 0, 0);
    drive(0, 10,  5, 0,  0, 4'b1100, 10,  5, 0, 0);
    drive(0, 10, 13, 0,  0, 4'b1100,  0, 13, 0, 0);
    drive(0, 10, 13, 0,  0, 4'b0011, 10, 13, 0, 0);
    drive(0, 10,  6, 1,  0, 4'b0111,  5,  6, 0, 0);
    drive(0, 10,  6, 1,  0, 4'b1111, 10,  6, 0, 0);
    drive(0, 15,  6, 1,  0, 4'b1110, 15,  6, 0, 0);
    drive(0,  9, 14, 1,  0, 4'b1110,  4, 14, 0, 0);
    drive(0, 15,  2, 2,  0, 4'b0000, 15,  2, 0, 0);
    drive(0, 10,  5, 3,  0, 4'b1111,  0,  0, 0, 0);
    drive(0, 10,  5, 2,  7, 4'b1111, 10,  5, 0, 0);
    drive(0, 10,  5, 2,  8, 4'b1111, 10,  5, 1, 0);
    drive(0, 10,  5, 0,  5, 4'b0011,  0,  5, 1, 0);
    drive(0, 10,  5, 0,  4, 4'b1111, 10,  5, 1, 0);
    drive(0, 12,  3, 1,  3, 4'b1011,  6,  3, 0, 0);
    drive(0,  7,  9, 2, 15, 4'b1111,  7,  9, 1, 0);
    drive(1,  7,  9, 2, 15, 4'b1111,  0,  0, 0, 0);
    drive(0,  7,  9, 2, 15, 4'b1111,  7,  9, 1, 0);
    drive(0,  7,  9, 2,  0, 4'b1111,  7,  9, 0, 0);
`ifdef DTMR_FAULT_INJ_EN
    for (int i = 0; i < 22; i++)
      drive(0, 10, 5, 2, 15, 4'b1111, 10, 5, 1, (i > 0));
`endif
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    if (inj_on) begin
      checks++;
      if (!seen_onehot) begin
        errors++;
        $display("FAIL inj_fault: one-hot fault seen %0d expected 1", seen_onehot);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dynamic_tmr.md
DYNAMIC_TMR -- requirements
Module: dynamic_tmr

Interface
REQ-001 Parameter TMR_ON_TH, default 8: err_rate value at or above which TMR operation is entered.
REQ-002 Parameter TMR_OFF_TH, default 4: err_rate value below which simplex operation is re-entered.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 speed  input  4  commanded speed, unsigned.
REQ-006 dir  input  4  commanded direction; bit 3 = 0 forward, 1 reverse; bits 2:0 heading.
REQ-007 mode  input  2  0 auto, 1 hybrid, 2 manual, 3 sleep.
REQ-008 err_rate  input  4  measured link error rate, unsigned.
REQ-009 f1, f2  input  1 each  front obstacle sensors, active low.
REQ-010 b1, b2  input  1 each  back obstacle sensors, active low.
REQ-011 speed_o  output  4  processed speed, registered.
REQ-012 dir_o  output  4  processed direction, registered.
REQ-013 fault  output  3  bit i set = processing replica i disagreed with voted result, registered.
REQ-014 state_o  output  1  0 simplex, 1 TMR; direct copy of state register.

Function
REQ-015 Three identical combinational replicas (0,1,2) SHALL each compute an 8-bit result {speed,dir} from the current inputs.
REQ-016 front_blk = ~f1 | ~f2; back_blk = ~b1 | ~b2; path_blk = dir[3] ? back_blk : front_blk.
REQ-017 Mode 0 auto: speed result = path_blk ? 0 : speed; dir result = dir.
REQ-018 Mode 1 hybrid: speed result = path_blk ? speed >> 1 : speed; dir result = dir.
REQ-019 Mode 2 manual: speed result = speed, dir result = dir, sensors ignored.
REQ-020 Mode 3 sleep: speed result = 0, dir result = 0.
REQ-021 State register: simplex -> TMR when err_rate >= TMR_ON_TH; TMR -> simplex when err_rate < TMR_OFF_TH; otherwise hold (hysteresis).
REQ-022 Output selection SHALL use the state register value before the current edge's update.
REQ-023 Simplex: outputs = replica 0 result; fault = 000.
REQ-024 TMR: outputs = bitwise 2-of-3 majority of the three 8-bit results; fault[i] = (replica i result != voted result).
REQ-025 If all three results differ, bitwise majority still drives outputs and every mismatching replica is flagged.
REQ-026 Latency: inputs sampled at edge N appear on speed_o/dir_o/fault at edge N (visible after edge N, one-cycle register).
REQ-027 No handshake; new inputs are accepted every cycle.

Reset
REQ-028 On rst=1 at a rising edge: speed_o=0, dir_o=0, fault=000, state register=0 (state_o=0), LFSR=8'hA5.
REQ-029 Reset asserted mid-operation SHALL override all other updates in that cycle; outputs resume on the first edge with rst=0.

Configuration
REQ-030 Macro DTMR_FAULT_INJ_EN defined: an 8-bit maximal-length LFSR (x^8+x^6+x^5+x^4+1) advances every cycle; when LFSR[3:0] < err_rate, replica selected by LFSR[5:4] mod 3 has bit 0 of its result inverted that cycle.
REQ-031 Macro not defined: no LFSR, no corruption; fault SHALL remain 000 in all states.

Verification
REQ-032 Auto, speed=10, dir=5, err_rate=0, {f1,f2,b1,b2}=0011 -> speed_o=0, dir_o=5; =1100 -> speed_o=10, dir_o=5; state_o=0.
REQ-033 Hybrid, speed=10, dir=6, sensors 0111 -> speed_o=5; sensors 1111 -> speed_o=10; dir_o=6.
REQ-034 Manual, speed=15, dir=2, sensors 0000 -> speed_o=15, dir_o=2; sleep mode, speed=10, dir=5 -> speed_o=0, dir_o=0.
REQ-035 err_rate 0->8 -> state_o=1 after next edge; 8->5 -> stays 1; 5->3 -> returns 0; fault=000 throughout without DTMR_FAULT_INJ_EN.
REQ-036 With DTMR_FAULT_INJ_EN, err_rate=15, manual, speed=10, dir=5 -> state_o=1 and within 20 cycles fault goes one-hot nonzero while speed_o=10, dir_o=5 every cycle.
REQ-037 rst pulsed for one cycle during TMR operation -> all outputs 0 and state_o=0 on that edge.
